icache_dm: RTL

Direct-mapped, read-only instruction cache between the CPU fetch port (PC/INSTRUCTION) and a slow, block-wide instruction memory.
- Hits return the instruction combinationally in the same cycle.
- Misses stall the CPU via BUSYWAIT while a 4-word block is fetched and written into the cache.
- Replaces the testbench's direct combinational instr_mem fetch; the CPU holds PC while BUSYWAIT=1.

---
 rtl/icache_dm_if.sv | 40 ++++
 rtl/icache_dm.sv | 122 ++++++++++++
 2 files changed

// File: rtl/icache_dm_if.sv
// icache_dm_if: fetch-side and memory-side signals of the instruction cache.
//   CPU side   : READ, ADDRESS -> INSTRUCTION, BUSYWAIT
//   Memory side: MEM_READ, MEM_ADDRESS -> MEM_READDATA, MEM_BUSYWAIT
//   Stats      : HIT_COUNT, MISS_COUNT (only with ICACHE_STATS_EN defined)
// modport slave is the cache's view; modport master is the view of the
// environment (CPU plus instruction memory) that drives it.
interface icache_dm_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int MADDR_W    = 6,
  parameter int BLK_W      = 128
);
  logic                  READ;
  logic [ADDR_WIDTH-1:0] ADDRESS;
  logic [31:0]           INSTRUCTION;
  logic                  BUSYWAIT;
  logic                  MEM_READ;
  logic [MADDR_W-1:0]    MEM_ADDRESS;
  logic [BLK_W-1:0]      MEM_READDATA;
  logic                  MEM_BUSYWAIT;
`ifdef ICACHE_STATS_EN
  logic [15:0]           HIT_COUNT;
  logic [15:0]           MISS_COUNT;
`endif

  modport slave (
    input  READ, ADDRESS, MEM_READDATA, MEM_BUSYWAIT,
`ifdef ICACHE_STATS_EN
    output HIT_COUNT, MISS_COUNT,
`endif
    output INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS
  );

  modport master (
    output READ, ADDRESS, MEM_READDATA, MEM_BUSYWAIT,
`ifdef ICACHE_STATS_EN
    input  HIT_COUNT, MISS_COUNT,
`endif
    input  INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS
  );
endinterface

// File: rtl/icache_dm.sv
// icache_dm: direct-mapped, read-only instruction cache.
//   CLK   : clock, all state on posedge
//   RESET : synchronous active-high reset (clears valid bits and FSM only)
//   bus   : icache_dm_if.slave -- fetch port (READ/ADDRESS/INSTRUCTION/
//           BUSYWAIT) and block memory port (MEM_READ/MEM_ADDRESS/
//           MEM_READDATA/MEM_BUSYWAIT)
// Hits answer combinationally; a miss stalls via BUSYWAIT while a whole
// block is fetched from memory and written into the line.
// Optional macro ICACHE_STATS_EN adds saturating HIT_COUNT / MISS_COUNT.
module icache_dm #(
  parameter int NUM_BLOCKS      = 8,
  parameter int WORDS_PER_BLOCK = 4,
  parameter int ADDR_WIDTH      = 10
) (
  input logic        CLK,
  input logic        RESET,
  icache_dm_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_BLOCKS);
  localparam int OFF_W = $clog2(WORDS_PER_BLOCK);
  localparam int TAG_W = ADDR_WIDTH - 2 - OFF_W - IDX_W;
  localparam int BLK_W = 32 * WORDS_PER_BLOCK;

  typedef enum logic {S_IDLE, S_MEM_READ} state_t;

  state_t state, state_nxt;

  logic [NUM_BLOCKS-1:0][BLK_W-1:0] data_q;
  logic [NUM_BLOCKS-1:0][TAG_W-1:0] tag_q;
  logic [NUM_BLOCKS-1:0]            valid_q;

  logic [TAG_W-1:0] miss_tag;
  logic [IDX_W-1:0] miss_index;

  logic [OFF_W-1:0] addr_off;
  logic [IDX_W-1:0] addr_idx;
  logic [TAG_W-1:0] addr_tag;
  logic [OFF_W+4:0] word_sel;
  logic             hit, miss_start, fill;
  logic             mem_read;
  logic [TAG_W+IDX_W-1:0] mem_addr;

  assign addr_off = bus.ADDRESS[2 +: OFF_W];
  assign addr_idx = bus.ADDRESS[2+OFF_W +: IDX_W];
  assign addr_tag = bus.ADDRESS[ADDR_WIDTH-1 -: TAG_W];
  assign word_sel = {addr_off, 5'd0};

  assign hit        = bus.READ & valid_q[addr_idx] & (tag_q[addr_idx] == addr_tag);
  assign miss_start = (state == S_IDLE) & bus.READ & ~hit;
  // fill completes on the edge where memory reports its data ready
  assign fill       = (state == S_MEM_READ) & ~bus.MEM_BUSYWAIT;

  assign bus.INSTRUCTION = data_q[addr_idx][word_sel +: 32];
  assign bus.BUSYWAIT    = (state != S_IDLE) | (bus.READ & ~hit);
  assign bus.MEM_READ    = mem_read;
  assign bus.MEM_ADDRESS = mem_addr;

  always_comb begin
    state_nxt = state;
    mem_read  = 1'b0;
    mem_addr  = '0;
    case (state)
      S_IDLE: begin
        if (miss_start) state_nxt = S_MEM_READ;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        // latched address: CPU-side ADDRESS may move during the fill
        mem_addr = {miss_tag, miss_index};
        if (!bus.MEM_BUSYWAIT) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= S_IDLE;
      miss_tag   <= '0;
      miss_index <= '0;
    end else begin
      state <= state_nxt;
      if (miss_start) begin
        miss_tag   <= addr_tag;
        miss_index <= addr_idx;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET)     valid_q             <= '0;
    else if (fill) valid_q[miss_index] <= 1'b1;
  end

  // data/tag arrays are never cleared; valid bits alone guard them.
  // RESET on the fill edge aborts the write.
  always_ff @(posedge CLK) begin
    if (!RESET && fill) begin
      data_q[miss_index] <= bus.MEM_READDATA;
      tag_q[miss_index]  <= miss_tag;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [15:0] hit_cnt, miss_cnt;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if ((state == S_IDLE) && hit && (hit_cnt != 16'hFFFF))
        hit_cnt <= hit_cnt + 16'd1;
      if (miss_start && (miss_cnt != 16'hFFFF))
        miss_cnt <= miss_cnt + 16'd1;
    end
  end

  assign bus.HIT_COUNT  = hit_cnt;
  assign bus.MISS_COUNT = miss_cnt;
`endif
endmodule
